// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, one-hot FSM states,
// byte-lane constants and the alignment rule used when a request is accepted.
package lsu_pkg;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 10;
  localparam int WORD_AW   = ADDR_W - 2;
  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  // Byte-address bits that select a lane inside the word; addr[1] alone picks a half.
  localparam int LANE_LSB  = 0;
  localparam int LANE_MSB  = 1;
  localparam int HALF_SEL  = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_READ_BIT  = 1;
  localparam int ST_WRITE_BIT = 2;
  localparam int ST_RESP_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_RESP  = 4'b1000
  } state_e;

  typedef struct packed {
    logic             we;
    size_e            size;
    logic             sgn;
    logic [1:0]       lane;
    logic [WIDTH-1:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[LANE_LSB];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response port of the load/store unit plus its word-wide memory port.
// The master side is the pipeline together with the memory; the slave is the LSU.
interface lsu_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;

  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_misaligned;

  logic              mem_wnr;
  logic [ADDR_W-3:0] mem_address;
  logic [WIDTH-1:0]  mem_in;
  logic [WIDTH-1:0]  mem_out;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
    input  mem_wnr, mem_address, mem_in,
    output mem_out
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
    output mem_wnr, mem_address, mem_in,
    input  mem_out
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: pulls a sub-word out of a memory word with
// sign/zero extension, and merges store data into a word preserving other lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       lane,
  input  size_e            size,
  input  logic             sgn,
  output logic [WIDTH-1:0] extracted,
  output logic [WIDTH-1:0] merged
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] lane_data;

  // Halfword requests only get here with lane[0]=0, so one lane shift serves both sizes.
  assign shamt   = {lane, 3'b000};
  assign shifted = word >> shamt;

  always_comb begin
    extracted = '0;
    case (size)
      SZ_BYTE: extracted = {{(WIDTH-BYTE_BITS){sgn & shifted[BYTE_BITS-1]}},
                            shifted[BYTE_BITS-1:0]};
      SZ_HALF: extracted = {{(WIDTH-HALF_BITS){sgn & shifted[HALF_BITS-1]}},
                            shifted[HALF_BITS-1:0]};
      default: extracted = word;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (size)
      SZ_BYTE: begin
        lane_mask = {{(WIDTH-BYTE_BITS){1'b0}}, {BYTE_BITS{1'b1}}} << shamt;
        lane_data = {{(WIDTH-BYTE_BITS){1'b0}}, wdata[BYTE_BITS-1:0]} << shamt;
      end
      SZ_HALF: begin
        lane_mask = {{(WIDTH-HALF_BITS){1'b0}}, {HALF_BITS{1'b1}}} << shamt;
        lane_data = {{(WIDTH-HALF_BITS){1'b0}}, wdata[HALF_BITS-1:0]} << shamt;
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata;
      end
    endcase
    merged = (word & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time through IDLE/READ/WRITE/RESP, with
// read-modify-write for sub-word stores and fault detection before any memory cycle.
module load_store_unit
  import lsu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  lsu_if.slave bus
);

  state_e               state_q;
  state_e               state_d;
  req_t                 req_q;
  logic [WIDTH-1:0]     rsp_rdata_q;
  logic                 rsp_misaligned_q;
  logic [WORD_AW-1:0]   mem_address_q;
  logic [WIDTH-1:0]     mem_in_q;
  logic [WIDTH-1:0]     extracted;
  logic [WIDTH-1:0]     merged;
  logic                 fault;
  logic                 word_store;

  assign fault      = is_misaligned(size_e'(bus.req_size), bus.req_addr[LANE_MSB:LANE_LSB]);
  assign word_store = bus.req_we && (bus.req_size == SZ_WORD);

  // Handshake and write strobe are straight flop outputs of the one-hot state.
  assign bus.req_ready      = state_q[ST_IDLE_BIT];
  assign bus.rsp_valid      = state_q[ST_RESP_BIT];
  assign bus.mem_wnr        = state_q[ST_WRITE_BIT];
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misaligned = rsp_misaligned_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_in         = mem_in_q;

  lsu_lane_align u_align (
    .word      (bus.mem_out),
    .wdata     (req_q.wdata),
    .lane      (req_q.lane),
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .extracted (extracted),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (fault)           state_d = ST_RESP;
          else if (word_store) state_d = ST_WRITE;
          else                 state_d = ST_READ;
        end
      end
      ST_READ:  state_d = req_q.we ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory-side registers only move on accept (or on the merge in READ), so they
  // stay stable for the whole write cycle and through the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q            <= '0;
      rsp_rdata_q      <= '0;
      rsp_misaligned_q <= 1'b0;
      mem_address_q    <= '0;
      mem_in_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_q.we         <= bus.req_we;
            req_q.size       <= size_e'(bus.req_size);
            req_q.sgn        <= bus.req_signed;
            req_q.lane       <= bus.req_addr[LANE_MSB:LANE_LSB];
            req_q.wdata      <= bus.req_wdata;
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= fault;
            if (!fault) begin
              mem_address_q <= bus.req_addr[ADDR_W-1:2];
              if (word_store) mem_in_q <= bus.req_wdata;
            end
          end
        end
        ST_READ: begin
          if (req_q.we) mem_in_q    <= merged;
          else          rsp_rdata_q <= extracted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-addressed reference memory
// predicts every response, latency, write strobe count and memory word.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus.mem_out = mem[bus.mem_address];

  always @(posedge clk) begin
    if (pre_en)           mem[pre_idx] <= pre_data;
    else if (bus.mem_wnr) mem[bus.mem_address] <= bus.mem_in;
  end

  logic [7:0] ref_mem [1024];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input int addr, input int nbytes, input logic sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[addr+i]) << (8*i));
    if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
    return v;
  endfunction

  // Drives one request at an IDLE negedge, then keeps garbage on the request
  // lines (valid still high) until the response shows up or the budget runs out.
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [9:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [31:0] rdata, output logic mis,
                                output int wnr_cycles, output logic wnr_accept,
                                output logic wnr_first, output logic ready_low,
                                output logic idle_after);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    wnr_accept     = bus.mem_wnr;
    @(posedge clk);
    lat        = 0;
    rdata      = 32'h0;
    mis        = 1'b0;
    wnr_cycles = 0;
    wnr_first  = 1'b0;
    ready_low  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = 10'($urandom);
      bus.req_wdata  = $urandom;
      if (c == 1) wnr_first = bus.mem_wnr;
      if (bus.mem_wnr) wnr_cycles++;
      if (bus.req_ready) ready_low = 1'b0;
      if (bus.rsp_valid) begin
        lat   = c;
        rdata = bus.rsp_rdata;
        mis   = bus.rsp_misaligned;
        break;
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    idle_after = bus.req_ready && !bus.rsp_valid;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [9:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    int nbytes, exp_lat, lat, wnr_cycles;
    logic exp_mis, mis, wnr_accept, wnr_first, ready_low, idle_after;
    logic [31:0] exp_rdata;
    nbytes    = 1 << int'(size);
    exp_mis   = (size == 2'b11) || ((int'(addr) % nbytes) != 0);
    exp_lat   = exp_mis ? 1 : (!we ? 2 : (size == 2'b10 ? 2 : 3));
    exp_rdata = (!we && !exp_mis) ? ref_load(int'(addr), nbytes, sgn) : 32'h0;
    if (we && !exp_mis)
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr)+i] = wdata[8*i +: 8];
    apply_stimulus(we, size, sgn, addr, wdata, lat, rdata, mis, wnr_cycles,
                   wnr_accept, wnr_first, ready_low, idle_after);
    check_output({tag, "/latency"},    32'(lat),        32'(exp_lat));
    check_output({tag, "/rdata"},      rdata,           exp_rdata);
    check_output({tag, "/misaligned"}, 32'(mis),        32'(exp_mis));
    check_output({tag, "/wnr_cycles"}, 32'(wnr_cycles), (we && !exp_mis) ? 32'd1 : 32'd0);
    check_output({tag, "/wnr_accept"}, 32'(wnr_accept), 32'd0);
    check_output({tag, "/wnr_first"},  32'(wnr_first),
                 (we && !exp_mis && size == 2'b10) ? 32'd1 : 32'd0);
    check_output({tag, "/ready_low"},  32'(ready_low),  32'd1);
    check_output({tag, "/idle_after"}, 32'(idle_after), 32'd1);
    check_output({tag, "/mem_word"},   mem[addr[9:2]],  ref_word(int'(addr[9:2])));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] rdata;
    logic        seen;
    logic        rsp_seen;

    rst_n          = 1'b0;
    pre_en         = 1'b0;
    pre_idx        = 8'h0;
    pre_data       = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h0;
    bus.req_wdata  = 32'h0;

    for (int i = 0; i < 256; i++) begin
      d = (i == 2) ? 32'h8070_F0A1 : $urandom;
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = 8'(i);
      pre_data = d;
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = d[8*k +: 8];
    end
    @(negedge clk);
    pre_en = 1'b0;

    check_output("reset/req_ready",      32'(bus.req_ready),      32'd1);
    check_output("reset/rsp_valid",      32'(bus.rsp_valid),      32'd0);
    check_output("reset/rsp_rdata",      bus.rsp_rdata,           32'd0);
    check_output("reset/rsp_misaligned", 32'(bus.rsp_misaligned), 32'd0);
    check_output("reset/mem_wnr",        32'(bus.mem_wnr),        32'd0);
    check_output("reset/mem_address",    32'(bus.mem_address),    32'd0);
    check_output("reset/mem_in",         bus.mem_in,              32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] directed accesses");

    run_op("ld_b_s", 1'b0, 2'b00, 1'b1, 10'h008, 32'h0, rdata);
    check_output("ld_b_s/const", rdata, 32'hFFFF_FFA1);
    run_op("ld_h_u", 1'b0, 2'b01, 1'b0, 10'h00A, 32'h0, rdata);
    check_output("ld_h_u/const", rdata, 32'h0000_8070);
    run_op("ld_h_s", 1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, rdata);
    check_output("ld_h_s/const", rdata, 32'hFFFF_8070);
    run_op("st_b",   1'b1, 2'b00, 1'b0, 10'h009, 32'h0000_0055, rdata);
    check_output("st_b/word2", mem[2], 32'h8070_55A1);
    run_op("st_w",   1'b1, 2'b10, 1'b0, 10'h3FC, 32'hDEAD_BEEF, rdata);
    check_output("st_w/word255", mem[255], 32'hDEAD_BEEF);
    run_op("ld_w_mis", 1'b0, 2'b10, 1'b0, 10'h006, 32'h0, rdata);
    run_op("st_h_mis", 1'b1, 2'b01, 1'b0, 10'h003, 32'h1234_5678, rdata);
    run_op("ld_ill",   1'b0, 2'b11, 1'b1, 10'h000, 32'h0, rdata);

    // Abort a sub-word store while its write strobe is up.
    $display("[TB] reset during write");
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h011;
    bus.req_wdata  = 32'h0000_00AB;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_wnr) seen = 1'b1;
    end
    check_output("rstw/wnr_seen", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rstw/wnr_drop",  32'(bus.mem_wnr),   32'd0);
    check_output("rstw/req_ready", 32'(bus.req_ready), 32'd1);
    rsp_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid) rsp_seen = 1'b1;
    check_output("rstw/no_rsp",    32'(rsp_seen),      32'd0);
    check_output("rstw/ready",     32'(bus.req_ready), 32'd1);
    check_output("rstw/word4",     mem[4],             ref_word(4));
    run_op("rstw_ld", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, rdata);

    $display("[TB] random accesses");
    for (int n = 0; n < 150; n++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [9:0]  addr;
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = 2'($urandom);
      addr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 63)) : 10'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      run_op("rand", we, size, sgn, addr, $urandom, rdata);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
